paddle_ctrl: RTL and testbench
==============================

# paddle_ctrl

Parametrised single-paddle controller for the Pong datapath. One instance drives one paddle; a mode input selects between player control and AI control. Player control follows debounced up/down buttons with hold-to-accelerate. AI control tracks the ball's y coordinate with a deadzone and an optional reaction lag. The block sits between the input/ball logic and the renderer/collision logic, and replaces the fixed-function paddle pair.

## Interface
Parameters:
- Y_W, 10, width of all y coordinates
- SCREEN_H, 480, visible screen height in pixels
- PADDLE_H, 64, paddle height in pixels
- SPEED_MIN, 2, player step per frame before acceleration
- SPEED_MAX, 6, player step per frame after acceleration
- ACCEL_FRAMES, 8, consecutive same-direction frames before SPEED_MAX applies
- AI_SPEED, 3, AI step per frame
- DEADZONE, 4, AI does not move while |ball_y − centre| ≤ DEADZONE
- AI_LAG, 4, AI reaction delay in frames (used only with PADDLE_AI_LAG_EN)

Ports:
- clk, in, 1, system clock
- reset, in, 1, asynchronous, active-high reset
- frame_tick, in, 1, one-cycle pulse per video frame; all motion happens on this pulse only
- ai_mode, in, 1, 0 = player control, 1 = AI control
- button_up, in, 1, move up (toward y = 0), already debounced
- button_down, in, 1, move down, already debounced
- ball_y, in, Y_W, ball top-edge y coordinate
- paddle_y, out, Y_W, paddle top-edge y coordinate
- moving, out, 1, paddle moved on the last frame_tick
- at_top, out, 1, paddle_y == 0
- at_bottom, out, 1, paddle_y == Y_MAX

## Operation
- Y_MAX = SCREEN_H − PADDLE_H. RESET_Y = Y_MAX/2, so the default is 208.
- Direction FSM has states HOLD, UP, DOWN. It is evaluated only on frame_tick and selects the direction applied on that tick.
- Player mode:
  - button_up only → UP. button_down only → DOWN. Neither or both → HOLD.
- AI mode:
  - centre = paddle_y + PADDLE_H/2. target = ball_y, or the lagged ball_y when lag is enabled.
  - target < centre − DEADZONE → UP. target > centre + DEADZONE → DOWN. Otherwise → HOLD.
  - The boundary is inclusive: a difference exactly equal to DEADZONE gives HOLD.
- Step size:
  - AI mode: always AI_SPEED.
  - Player mode: SPEED_MIN while accel_cnt < ACCEL_FRAMES, otherwise SPEED_MAX.
- accel_cnt:
  - Increments, saturating at ACCEL_FRAMES, on each tick whose direction equals the previous tick's non-HOLD direction.
  - Resets to 0 on HOLD, on a direction reversal, and on any ai_mode change.
  - After reset to 0, the first tick in the new direction uses count 0.
- Arithmetic:
  - Compute the next position at width Y_W+1.
  - UP: if paddle_y < step, next = 0.
  - DOWN: if paddle_y + step > Y_MAX, next = Y_MAX.
  - No wrap-around is permitted.
- moving = 1 when next ≠ paddle_y. A clamped no-op at a wall gives moving = 0.
- ai_mode is sampled at frame_tick; a change takes effect on that tick.

## Timing
- Reset values: paddle_y = RESET_Y, moving = 0, at_top = 0, at_bottom = 0, FSM = HOLD, accel_cnt = 0, lag line filled with RESET_Y + PADDLE_H/2.
- All outputs are registered. A frame_tick in cycle N is reflected on the outputs in cycle N+1.
- Outside frame_tick, paddle_y, moving, at_top and at_bottom hold their values.
- Inputs are sampled in the frame_tick cycle only. Input changes between ticks are ignored.
- Reset asserted mid-frame returns all state to reset values immediately. The first tick after reset deassertion behaves as the first tick from RESET_Y.
- frame_tick asserted on consecutive cycles is legal; each cycle is a full step.

## Configuration
- PADDLE_AI_LAG_EN defined:
  - ball_y is pushed into an AI_LAG-deep shift register on each frame_tick.
  - The AI target is the oldest entry, so the AI reacts AI_LAG frames late.
- PADDLE_AI_LAG_EN undefined:
  - No shift register is built. The target is ball_y as sampled in the tick cycle, and AI_LAG is ignored.
- Player mode is unaffected either way.

## Structure
- paddle_pkg holds:
  - the dir_e enum (DIR_HOLD, DIR_UP, DIR_DOWN)
  - the default constants SCREEN_H, PADDLE_H and Y_W
  - the function clamp_step(pos, step, dir, y_max)
- Sub-module paddle_ai_track contains the lag line and the deadzone compare, and outputs a dir_e request. paddle_ctrl contains the mode mux, the FSM/accel_cnt and the position register.

## Test plan
All scenarios use default parameters unless stated.
- Reset → paddle_y = 208, moving = 0, at_top = 0, at_bottom = 0. The outputs hold across 100 cycles with no frame_tick.
- Player mode, button_up held for 3 ticks → paddle_y = 206, 204, 202, with moving = 1 each tick.
- Player mode, button_up held for 10 ticks → paddle_y = 180 (8 × 2 + 2 × 6). Then release for 1 tick and press again → the next step is 2.
- Clamp: from paddle_y = 4, hold up at SPEED_MAX → 0, at_top = 1. A further tick gives moving = 0. Symmetric case: from 412, down at SPEED_MAX → 416, at_bottom = 1. Both buttons pressed → no motion.
- AI mode, PADDLE_AI_LAG_EN undefined:
  - paddle_y = 208 (centre 240), ball_y = 400 → 211, 214, 217 over 3 ticks.
  - ball_y = 244 → no move.
  - ball_y = 245 → move down by 3.
- AI mode, PADDLE_AI_LAG_EN defined, AI_LAG = 4: at rest, step ball_y from 240 to 400 → paddle_y is unchanged for 4 ticks and starts moving on tick 5. A reset pulse mid-sequence → 208 on the next cycle.

Source files
------------

// File: rtl/paddle_pkg.sv
// Shared direction type, default geometry and the clamped-step helper for paddle_ctrl.
package paddle_pkg;

   typedef enum logic [1:0] {
      DIR_HOLD = 2'd0,
      DIR_UP   = 2'd1,
      DIR_DOWN = 2'd2
   } dir_e;

   localparam int unsigned SCREEN_H = 480;
   localparam int unsigned PADDLE_H = 64;
   localparam int unsigned Y_W      = 10;

   // 32-bit operands leave headroom above any legal Y_W, so pos + step cannot wrap.
   function automatic logic [31:0] clamp_step(input logic [31:0] pos, input logic [31:0] step,
                                              input dir_e dir, input logic [31:0] y_max);
      logic [31:0] res;
      res = pos;
      unique case (dir)
         DIR_UP:   res = (pos < step) ? 32'd0 : pos - step;
         DIR_DOWN: res = (pos + step > y_max) ? y_max : pos + step;
         default:  res = pos;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/paddle_ai_track.sv
// AI direction request: deadzone compare of the ball against the paddle centre.
// With PADDLE_AI_LAG_EN defined, the ball is seen through an AI_LAG-deep frame delay line.
module paddle_ai_track
   import paddle_pkg::*;
#(
   parameter int unsigned Y_W      = paddle_pkg::Y_W,
   parameter int unsigned PADDLE_H = paddle_pkg::PADDLE_H,
   parameter int unsigned DEADZONE = 4
`ifdef PADDLE_AI_LAG_EN
   ,
   parameter int unsigned AI_LAG   = 4,
   parameter int unsigned RESET_Y  = 208
`endif
) (
`ifdef PADDLE_AI_LAG_EN
   input  logic           clk_i,
   input  logic           rst_i,
   input  logic           tick_i,
`endif
   input  logic [Y_W-1:0] ball_y_i,
   input  logic [Y_W-1:0] paddle_y_i,
   output dir_e           dir_o
);

   localparam int unsigned CW = Y_W + 2;
   localparam logic [CW-1:0] HalfH = CW'(PADDLE_H / 2);
   localparam logic [CW-1:0] Dz    = CW'(DEADZONE);

   logic [Y_W-1:0] target;

`ifdef PADDLE_AI_LAG_EN
   localparam logic [Y_W-1:0] LagInit = Y_W'(RESET_Y + PADDLE_H / 2);

   logic [Y_W-1:0] lag_q [AI_LAG];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < int'(AI_LAG); i++) lag_q[i] <= LagInit;
      end else if (tick_i) begin
         lag_q[0] <= ball_y_i;
         for (int i = 1; i < int'(AI_LAG); i++) lag_q[i] <= lag_q[i-1];
      end
   end

   assign target = lag_q[AI_LAG-1];
`else
   assign target = ball_y_i;
`endif

   logic [CW-1:0] centre, tgt_w;

   assign centre = CW'(paddle_y_i) + HalfH;
   assign tgt_w  = CW'(target);

   // Compare with DEADZONE added on the other side so nothing goes negative.
   always_comb begin
      dir_o = DIR_HOLD;
      if (tgt_w + Dz < centre) begin
         dir_o = DIR_UP;
      end else if (tgt_w > centre + Dz) begin
         dir_o = DIR_DOWN;
      end
   end

endmodule

// File: rtl/paddle_ctrl.sv
// Single-paddle controller: player buttons with hold-to-accelerate, or AI ball tracking.
// Optional AI reaction lag is built when PADDLE_AI_LAG_EN is defined.
module paddle_ctrl
   import paddle_pkg::*;
#(
   parameter int unsigned Y_W          = paddle_pkg::Y_W,
   parameter int unsigned SCREEN_H     = paddle_pkg::SCREEN_H,
   parameter int unsigned PADDLE_H     = paddle_pkg::PADDLE_H,
   parameter int unsigned SPEED_MIN    = 2,
   parameter int unsigned SPEED_MAX    = 6,
   parameter int unsigned ACCEL_FRAMES = 8,
   parameter int unsigned AI_SPEED     = 3,
   parameter int unsigned DEADZONE     = 4,
   parameter int unsigned AI_LAG       = 4
) (
   input  logic           clk_i,
   input  logic           rst_i,
   input  logic           frame_tick_i,
   input  logic           ai_mode_i,
   input  logic           button_up_i,
   input  logic           button_down_i,
   input  logic [Y_W-1:0] ball_y_i,
   output logic [Y_W-1:0] paddle_y_o,
   output logic           moving_o,
   output logic           at_top_o,
   output logic           at_bottom_o
);

   localparam int unsigned     CntW     = $clog2(ACCEL_FRAMES + 1);
   localparam logic [Y_W-1:0]  YMax     = Y_W'(SCREEN_H - PADDLE_H);
   localparam logic [Y_W-1:0]  ResetY   = Y_W'((SCREEN_H - PADDLE_H) / 2);
   localparam logic [CntW-1:0] AccelSat = CntW'(ACCEL_FRAMES);

   if (AI_LAG < 1) begin : g_bad_lag
      $error("AI_LAG must be at least 1");
   end

   dir_e            dir_q, dir_d;
   logic [CntW-1:0] accel_cnt_q, accel_cnt_d;
   logic            mode_q, mode_d;
   logic [Y_W-1:0]  paddle_y_q, paddle_y_d;
   logic            moving_q, moving_d;
   logic            at_top_q, at_top_d;
   logic            at_bottom_q, at_bottom_d;

   dir_e            player_dir, ai_dir, req_dir;
   logic [CntW-1:0] cnt_eff;
   logic [31:0]     step;
   logic [Y_W-1:0]  next_y;

   paddle_ai_track #(
      .Y_W      (Y_W),
      .PADDLE_H (PADDLE_H),
      .DEADZONE (DEADZONE)
`ifdef PADDLE_AI_LAG_EN
      ,
      .AI_LAG   (AI_LAG),
      .RESET_Y  ((SCREEN_H - PADDLE_H) / 2)
`endif
   ) u_ai_track (
`ifdef PADDLE_AI_LAG_EN
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .tick_i     (frame_tick_i),
`endif
      .ball_y_i   (ball_y_i),
      .paddle_y_i (paddle_y_q),
      .dir_o      (ai_dir)
   );

   always_comb begin
      player_dir = DIR_HOLD;
      if (button_up_i && !button_down_i) begin
         player_dir = DIR_UP;
      end else if (button_down_i && !button_up_i) begin
         player_dir = DIR_DOWN;
      end
   end

   assign req_dir = ai_mode_i ? ai_dir : player_dir;

   always_comb begin
      dir_d       = dir_q;
      accel_cnt_d = accel_cnt_q;
      mode_d      = mode_q;
      paddle_y_d  = paddle_y_q;
      moving_d    = moving_q;
      at_top_d    = at_top_q;
      at_bottom_d = at_bottom_q;
      cnt_eff     = '0;
      step        = 32'(SPEED_MIN);
      next_y      = paddle_y_q;
      if (frame_tick_i) begin
         // Acceleration only continues an unbroken run in one direction and one mode.
         if (req_dir != DIR_HOLD && req_dir == dir_q && ai_mode_i == mode_q) begin
            cnt_eff = (accel_cnt_q == AccelSat) ? accel_cnt_q : accel_cnt_q + CntW'(1);
         end
         if (ai_mode_i) begin
            step = 32'(AI_SPEED);
         end else if (cnt_eff >= AccelSat) begin
            step = 32'(SPEED_MAX);
         end
         next_y      = Y_W'(clamp_step(32'(paddle_y_q), step, req_dir, 32'(YMax)));
         dir_d       = req_dir;
         accel_cnt_d = cnt_eff;
         mode_d      = ai_mode_i;
         paddle_y_d  = next_y;
         moving_d    = (next_y != paddle_y_q);
         at_top_d    = (next_y == '0);
         at_bottom_d = (next_y == YMax);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         dir_q       <= DIR_HOLD;
         accel_cnt_q <= '0;
         mode_q      <= 1'b0;
         paddle_y_q  <= ResetY;
         moving_q    <= 1'b0;
         at_top_q    <= 1'b0;
         at_bottom_q <= 1'b0;
      end else begin
         dir_q       <= dir_d;
         accel_cnt_q <= accel_cnt_d;
         mode_q      <= mode_d;
         paddle_y_q  <= paddle_y_d;
         moving_q    <= moving_d;
         at_top_q    <= at_top_d;
         at_bottom_q <= at_bottom_d;
      end
   end

   assign paddle_y_o  = paddle_y_q;
   assign moving_o    = moving_q;
   assign at_top_o    = at_top_q;
   assign at_bottom_o = at_bottom_q;

endmodule

// File: tb/tb_paddle_ctrl.sv
// Directed and randomized checks of paddle_ctrl against a frame-level behavioural model.
module tb_paddle_ctrl;

   localparam int YMAX   = 416;
   localparam int RESETY = 208;
   localparam int HALF   = 32;
   localparam int SMIN   = 2;
   localparam int SMAX   = 6;
   localparam int ACC    = 8;
   localparam int AIS    = 3;
   localparam int DZ     = 4;
   localparam int LAG    = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       frame_tick = 1'b0;
   logic       ai_mode = 1'b0;
   logic       bu = 1'b0;
   logic       bd = 1'b0;
   logic [9:0] ball_y = '0;
   logic [9:0] paddle_y;
   logic       moving, at_top, at_bottom;

   int n_cmp  = 0;
   int n_fail = 0;

   // Model state: position, last tick's direction (-1/0/+1), run length, last mode.
   int m_y, m_prev, m_run, m_mode, m_moving;
   int m_lag[$];

   always #5 clk = ~clk;

   paddle_ctrl u_dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .frame_tick_i  (frame_tick),
      .ai_mode_i     (ai_mode),
      .button_up_i   (bu),
      .button_down_i (bd),
      .ball_y_i      (ball_y),
      .paddle_y_o    (paddle_y),
      .moving_o      (moving),
      .at_top_o      (at_top),
      .at_bottom_o   (at_bottom)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag);
      chk({tag, ".y"}, 32'(paddle_y), 32'(m_y));
      chk({tag, ".moving"}, 32'(moving), 32'(m_moving));
      chk({tag, ".top"}, 32'(at_top), 32'(m_y == 0));
      chk({tag, ".bottom"}, 32'(at_bottom), 32'(m_y == YMAX));
   endtask

   task automatic model_reset();
      m_y = RESETY; m_prev = 0; m_run = 0; m_mode = 0; m_moving = 0;
      m_lag = {};
      repeat (LAG) m_lag.push_back(RESETY + HALF);
   endtask

   task automatic model_tick(input int up, input int dn, input int ai, input int ball);
      int dir, target, diff, step, nxt;
      if (ai != 0) begin
         target = ball;
`ifdef PADDLE_AI_LAG_EN
         target = m_lag[0];
`endif
         diff = target - (m_y + HALF);
         dir  = (diff < -DZ) ? -1 : (diff > DZ) ? 1 : 0;
      end else begin
         dir = (up != 0 && dn == 0) ? -1 : (dn != 0 && up == 0) ? 1 : 0;
      end
`ifdef PADDLE_AI_LAG_EN
      m_lag.push_back(ball);
      void'(m_lag.pop_front());
`endif
      if (dir != 0 && dir == m_prev && ai == m_mode) m_run = (m_run < ACC) ? m_run + 1 : ACC;
      else m_run = 0;
      step = (ai != 0) ? AIS : ((m_run >= ACC) ? SMAX : SMIN);
      nxt  = m_y + dir * step;
      if (nxt < 0) nxt = 0;
      if (nxt > YMAX) nxt = YMAX;
      m_moving = (nxt != m_y) ? 1 : 0;
      m_y    = nxt;
      m_prev = dir;
      m_mode = ai;
   endtask

   task automatic cycle(input int tick, input int up, input int dn, input int ai, input int ball,
                        input string tag);
      @(negedge clk);
      frame_tick = (tick != 0);
      bu         = (up != 0);
      bd         = (dn != 0);
      ai_mode    = (ai != 0);
      ball_y     = 10'(ball);
      @(posedge clk);
      if (tick != 0) model_tick(up, dn, ai, ball);
      #1;
      chk_all(tag);
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      frame_tick = 1'b0;
      rst = 1'b1;
      #1;
      model_reset();
      chk_all(tag);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int tk, up, dn, ai, ball;
      model_reset();
      rst = 1'b1;
      #12;
      chk_all("reset");
      @(negedge clk);
      rst = 1'b0;

      // Outputs hold with no frame_tick, whatever the inputs do.
      for (int i = 0; i < 100; i++)
         cycle(0, int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
               int'($urandom_range(0, 1)), int'($urandom_range(0, 479)), "idle");
      chk("idle_y_208", 32'(paddle_y), 32'd208);

      // Up for 3 ticks.
      cycle(1, 1, 0, 0, 0, "up3a"); chk("up3a_lit", 32'(paddle_y), 32'd206);
      cycle(1, 1, 0, 0, 0, "up3b"); chk("up3b_lit", 32'(paddle_y), 32'd204);
      cycle(1, 1, 0, 0, 0, "up3c"); chk("up3c_lit", 32'(paddle_y), 32'd202);
      chk("up3c_mov", 32'(moving), 32'd1);

      // Reset mid-frame takes effect immediately.
      do_reset("rst_mid");

      // Acceleration run, release, re-press, then into the top wall.
      for (int i = 0; i < 10; i++) cycle(1, 1, 0, 0, 0, "acc10");
      chk("acc10_lit", 32'(paddle_y), 32'd180);
      cycle(1, 0, 0, 0, 0, "release"); chk("release_mov", 32'(moving), 32'd0);
      cycle(1, 1, 0, 0, 0, "repress"); chk("repress_lit", 32'(paddle_y), 32'd178);
      cycle(1, 1, 0, 0, 0, "repress2");
      cycle(1, 0, 0, 0, 0, "hold2");
      for (int i = 0; i < 34; i++) cycle(1, 1, 0, 0, 0, "toward_top");
      chk("at4_lit", 32'(paddle_y), 32'd4);
      cycle(1, 1, 0, 0, 0, "clamp_top");
      chk("clamp_top_lit", 32'(paddle_y), 32'd0);
      chk("clamp_top_flag", 32'(at_top), 32'd1);
      cycle(1, 1, 0, 0, 0, "wall_top"); chk("wall_top_mov", 32'(moving), 32'd0);

      // Bottom wall: 208 -> 210, pause, then 39 ticks down to 412.
      do_reset("rst_b");
      cycle(1, 0, 1, 0, 0, "dn1");
      cycle(1, 0, 0, 0, 0, "dn_hold");
      for (int i = 0; i < 39; i++) cycle(1, 0, 1, 0, 0, "toward_bot");
      chk("at412_lit", 32'(paddle_y), 32'd412);
      cycle(1, 0, 1, 0, 0, "clamp_bot");
      chk("clamp_bot_lit", 32'(paddle_y), 32'd416);
      chk("clamp_bot_flag", 32'(at_bottom), 32'd1);
      cycle(1, 1, 1, 0, 0, "both"); chk("both_mov", 32'(moving), 32'd0);

`ifndef PADDLE_AI_LAG_EN
      do_reset("rst_ai");
      cycle(1, 0, 0, 1, 400, "ai400a"); chk("ai400a_lit", 32'(paddle_y), 32'd211);
      cycle(1, 0, 0, 1, 400, "ai400b"); chk("ai400b_lit", 32'(paddle_y), 32'd214);
      cycle(1, 0, 0, 1, 400, "ai400c"); chk("ai400c_lit", 32'(paddle_y), 32'd217);
      do_reset("rst_dz");
      cycle(1, 0, 0, 1, 244, "dz244"); chk("dz244_lit", 32'(paddle_y), 32'd208);
      cycle(1, 0, 0, 1, 245, "dz245"); chk("dz245_lit", 32'(paddle_y), 32'd211);
      do_reset("rst_dzu");
      cycle(1, 0, 0, 1, 236, "dz236"); chk("dz236_lit", 32'(paddle_y), 32'd208);
      cycle(1, 0, 0, 1, 235, "dz235"); chk("dz235_lit", 32'(paddle_y), 32'd205);
`else
      do_reset("rst_lag");
      for (int i = 0; i < LAG; i++) begin
         cycle(1, 0, 0, 1, 400, "lag_wait");
         chk("lag_wait_lit", 32'(paddle_y), 32'd208);
      end
      cycle(1, 0, 0, 1, 400, "lag_go"); chk("lag_go_lit", 32'(paddle_y), 32'd211);
      cycle(1, 0, 0, 1, 400, "lag_go2");
      do_reset("rst_lag_mid");
      chk("rst_lag_mid_lit", 32'(paddle_y), 32'd208);
      cycle(1, 0, 0, 1, 400, "lag_after_rst");
`endif

      // Randomized run: mode flips, back-to-back ticks, deadzone-edge balls, async resets.
      do_reset("rst_rand");
      ai = 0;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 149) == 0) begin
            do_reset("rand_rst");
         end else begin
            if ($urandom_range(0, 19) == 0) ai = 1 - ai;
            tk = ($urandom_range(0, 9) < 6) ? 1 : 0;
            up = ($urandom_range(0, 3) != 0) ? 1 : 0;
            dn = ($urandom_range(0, 3) == 0) ? 1 : 0;
            if ($urandom_range(0, 49) < 3) begin up = 1 - up; dn = 1 - dn; end
            if ($urandom_range(0, 1) == 1) ball = int'($urandom_range(0, 479));
            else ball = m_y + HALF + int'($urandom_range(0, 12)) - 6;
            if (ball < 0) ball = 0;
            if (ball > 1023) ball = 1023;
            cycle(tk, up, dn, ai, ball, "rand");
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
